// File: rtl/bto.sv
// Bus timeout monitor.
// Sits between the CPU bus master port and the address decoder / acknowledge
// multiplexer. Bus cycles pass through combinationally; a cycle that is not
// acknowledged within TIMEOUT strobe cycles is ended by a one-cycle synthetic
// acknowledge with zero read data. The first faulting access is recorded, a
// saturating fault count is kept, and a level interrupt can be raised.
// Software uses a two-word register window (status/control, fault address).
module bto #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // CPU master side
  input  logic        m_stb,
  input  logic        m_we,
  input  logic [21:0] m_addr,
  output logic [31:0] m_din,
  output logic        m_ack,
  // decoder / multiplexer side
  output logic        s_stb,
  input  logic [31:0] s_din,
  input  logic        s_ack,
  // register window
  input  logic        reg_stb,
  input  logic        reg_we,
  input  logic        reg_addr,
  input  logic [31:0] reg_data_in,
  output logic [31:0] reg_data_out,
  output logic        reg_ack,
  output logic        irq
);

  // Last count value at which an un-acknowledged strobe is still allowed.
  localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT - 1);

  typedef enum logic {
    RUN,
    ABORT
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [15:0] r_cnt;
  logic        r_flag;
  logic        r_ien;
  logic        r_fault_we;
  logic [21:0] r_fault_addr;
  logic [7:0]  r_fault_cnt;

  logic        w_pending;
  logic        w_fault;
  logic        w_wr_ctrl;
  logic        w_clr_flag;
  logic        w_clr_fcnt;
  logic        w_latch;
  logic [31:0] w_reg0;
  logic [31:0] w_reg1;
  logic        w_unused;

  // Control-register bits 30..2 have no function.
  assign w_unused = ^reg_data_in[30:2];

  // A strobe is outstanding and nobody answered it this cycle.
  assign w_pending = (r_state == RUN) && m_stb && !s_ack;

  // Timeout fires on the edge where the last allowed cycle also goes unanswered;
  // an acknowledge on that same edge wins because w_pending is then low.
  assign w_fault = w_pending && (r_cnt == CNT_LIMIT);

  // Status/control register write decode.
  assign w_wr_ctrl  = reg_stb && reg_we && !reg_addr;
  assign w_clr_flag = w_wr_ctrl && reg_data_in[0];
  assign w_clr_fcnt = w_wr_ctrl && reg_data_in[31];

  // Fault address is captured for the first fault only, or again when software
  // clears the flag on the very edge a new fault arrives.
  assign w_latch = w_fault && (!r_flag || w_clr_flag);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: ABORT lasts exactly one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN:     if (w_fault) w_next_state = ABORT;
      ABORT:   w_next_state = RUN;
      default: w_next_state = RUN;
    endcase
  end

  // Output logic: transparent in RUN, synthetic zero-data acknowledge in ABORT.
  always_comb begin
    s_stb = m_stb;
    m_ack = s_ack;
    m_din = s_din;
    case (r_state)
      RUN: begin
        s_stb = m_stb;
        m_ack = s_ack;
        m_din = s_din;
      end
      ABORT: begin
        s_stb = 1'b0;
        m_ack = 1'b1;
        m_din = '0;
      end
      default: begin
        s_stb = m_stb;
        m_ack = s_ack;
        m_din = s_din;
      end
    endcase
  end

  // Wait-cycle counter: counts unanswered strobe cycles, restarts on any ack,
  // idle cycle, or timeout, and is held at zero through ABORT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_pending && (r_cnt != CNT_LIMIT)) begin
      r_cnt <= r_cnt + 16'd1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Fault flag: a new fault dominates a simultaneous software clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag <= 1'b0;
    end else if (w_fault) begin
      r_flag <= 1'b1;
    end else if (w_clr_flag) begin
      r_flag <= 1'b0;
    end
  end

  // Interrupt enable, loaded by every status/control write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ien <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_ien <= reg_data_in[1];
    end
  end

  // First-fault capture of address and direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault_addr <= '0;
      r_fault_we   <= 1'b0;
    end else if (w_latch) begin
      r_fault_addr <= m_addr;
      r_fault_we   <= m_we;
    end
  end

  // Saturating fault counter; a clear coinciding with a fault leaves it at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault_cnt <= '0;
    end else if (w_clr_fcnt) begin
      r_fault_cnt <= w_fault ? 8'd1 : 8'd0;
    end else if (w_fault && (r_fault_cnt != '1)) begin
      r_fault_cnt <= r_fault_cnt + 8'd1;
    end
  end

  // Register read values.
  always_comb begin
    w_reg0        = '0;
    w_reg0[0]     = r_flag;
    w_reg0[1]     = r_ien;
    w_reg0[2]     = r_fault_we;
    w_reg0[15:8]  = r_fault_cnt;
    w_reg1        = {8'h00, r_fault_addr, 2'b00};
  end

  // Zero-wait-state register read mux, driven low when not selected.
  always_comb begin
    reg_data_out = '0;
    if (reg_stb) begin
      reg_data_out = reg_addr ? w_reg1 : w_reg0;
    end
  end

  assign reg_ack = reg_stb;
  assign irq     = r_flag && r_ien;

endmodule
